// File: rtl/windowed_register_file_if.sv
// Operand-read / writeback bus of the windowed integer register file.
interface windowed_register_file_if #(
    parameter int DATA_W = 32,
    parameter int CWP_W  = 3
);
    logic [CWP_W-1:0]  cwp;
    logic              rd_en;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              wr_en;
    logic [4:0]        rd;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              rd_valid;

    modport master (
        output cwp, rd_en, rs1, rs2, wr_en, rd, wr_data,
        input  rs1_data, rs2_data, rd_valid
    );

    modport slave (
        input  cwp, rd_en, rs1, rs2, wr_en, rd, wr_data,
        output rs1_data, rs2_data, rd_valid
    );
endinterface

// File: rtl/windowed_register_file.sv
// SPARC V8 windowed integer register file: 8 globals + NWIN x 16 windowed regs, two registered read ports.
// Define RF_WR_BYPASS_EN for write-first reads on a same-cycle collision; default is read-first.
module windowed_register_file #(
    parameter int DATA_W = 32,
    parameter int CWP_W  = 3
) (
    input  logic                      Clk,
    input  logic                      Clr,
    windowed_register_file_if.slave   bus
);
    localparam int NWIN     = 1 << CWP_W;
    localparam int WIN_REGS = NWIN * 16;
    localparam int IDX_W    = CWP_W + 4;
    localparam int KEY_W    = IDX_W + 1;

    logic [DATA_W-1:0] glob_q [8];
    logic [DATA_W-1:0] glob_d [8];
    logic [DATA_W-1:0] win_q  [WIN_REGS];
    logic [DATA_W-1:0] win_d  [WIN_REGS];
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q, rs2_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic [KEY_W-1:0]  wr_key, rs1_key, rs2_key;
    logic              wr_live;
    logic [DATA_W-1:0] rs1_val, rs2_val;

    // Key MSB set = global bank; otherwise the low IDX_W bits index the window bank.
    // The ins of window w are the outs of window w+1, which wraps naturally in CWP_W bits.
    function automatic logic [KEY_W-1:0] phys_key(input logic [4:0] r, input logic [CWP_W-1:0] w);
        logic [CWP_W-1:0] w_next;
        logic [KEY_W-1:0] key;
        w_next = w + CWP_W'(1);
        case (r[4:3])
            2'b00:   key = {1'b1, {(IDX_W-3){1'b0}}, r[2:0]};
            2'b01:   key = {1'b0, w, 1'b0, r[2:0]};
            2'b10:   key = {1'b0, w, 1'b1, r[2:0]};
            default: key = {1'b0, w_next, 1'b0, r[2:0]};
        endcase
        return key;
    endfunction

    always_comb begin
        glob_d     = glob_q;
        win_d      = win_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_valid_d = bus.rd_en;

        wr_key  = phys_key(bus.rd,  bus.cwp);
        rs1_key = phys_key(bus.rs1, bus.cwp);
        rs2_key = phys_key(bus.rs2, bus.cwp);
        wr_live = bus.wr_en && (bus.rd != 5'd0);

        if (wr_live) begin
            if (wr_key[KEY_W-1]) glob_d[wr_key[2:0]]       = bus.wr_data;
            else                 win_d[wr_key[IDX_W-1:0]]  = bus.wr_data;
        end

        rs1_val = rs1_key[KEY_W-1] ? glob_q[rs1_key[2:0]] : win_q[rs1_key[IDX_W-1:0]];
        rs2_val = rs2_key[KEY_W-1] ? glob_q[rs2_key[2:0]] : win_q[rs2_key[IDX_W-1:0]];
`ifdef RF_WR_BYPASS_EN
        if (wr_live && (wr_key == rs1_key)) rs1_val = bus.wr_data;
        if (wr_live && (wr_key == rs2_key)) rs2_val = bus.wr_data;
`else
`endif
        if (bus.rs1 == 5'd0) rs1_val = '0;
        if (bus.rs2 == 5'd0) rs2_val = '0;

        if (bus.rd_en) begin
            rs1_data_d = rs1_val;
            rs2_data_d = rs2_val;
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            for (int i = 0; i < 8; i++)        glob_q[i] <= '0;
            for (int i = 0; i < WIN_REGS; i++) win_q[i]  <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            glob_q     <= glob_d;
            win_q      <= win_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rs1_data = rs1_data_q;
    assign bus.rs2_data = rs2_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_windowed_register_file.sv
// Directed bench for windowed_register_file: reset, %g0, window overlap/wrap, collision, hold.
module tb_windowed_register_file;
    logic Clk;
    logic Clr;
    int   tests    = 0;
    int   failures = 0;

    logic [31:0] rand_a, rand_b, rand_c;
    logic [31:0] coll_exp;

    windowed_register_file_if #(.DATA_W(32), .CWP_W(3)) bus ();

    windowed_register_file #(.DATA_W(32), .CWP_W(3)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request cycle, then sample 1 time unit after the capturing edge.
    task automatic cyc(input logic re, input logic [4:0] a, input logic [4:0] b,
                       input logic we, input logic [4:0] d, input logic [31:0] data,
                       input logic [2:0] w);
        bus.rd_en   = re;
        bus.rs1     = a;
        bus.rs2     = b;
        bus.wr_en   = we;
        bus.rd      = d;
        bus.wr_data = data;
        bus.cwp     = w;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 3'd0);
    endtask

    initial begin
        Clr = 1'b0;
        bus.rd_en = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.wr_en = 1'b0;
        bus.rd = '0; bus.wr_data = '0; bus.cwp = '0;
        #1;
        chk("por_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
        chk("por_rs1_data", bus.rs1_data, 32'h0);
        repeat (2) @(posedge Clk);
        #1;
        Clr = 1'b1;

        // 1: random contents, then async clear mid-cycle
        rand_a = $urandom() | 32'h1;
        rand_b = $urandom() | 32'h1;
        rand_c = $urandom() | 32'h1;
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd5,  rand_a, 3'd2);
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd20, rand_b, 3'd2);
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd9,  rand_c, 3'd4);
        cyc(1'b1, 5'd5, 5'd20, 1'b0, 5'd0, 32'h0, 3'd2);
        chk("pre_rst_rs1", bus.rs1_data, rand_a);
        chk("pre_rst_rs2", bus.rs2_data, rand_b);
        chk("pre_rst_valid", {31'b0, bus.rd_valid}, 32'h1);
        #2;
        Clr = 1'b0;
        #1;
        chk("clr_rs1_async", bus.rs1_data, 32'h0);
        chk("clr_rs2_async", bus.rs2_data, 32'h0);
        chk("clr_valid_async", {31'b0, bus.rd_valid}, 32'h0);
        cyc(1'b1, 5'd5, 5'd20, 1'b0, 5'd0, 32'h0, 3'd2);
        chk("clr_held_valid", {31'b0, bus.rd_valid}, 32'h0);
        Clr = 1'b1;
        cyc(1'b1, 5'd5, 5'd20, 1'b0, 5'd0, 32'h0, 3'd2);
        chk("post_rst_g5", bus.rs1_data, 32'h0);
        chk("post_rst_l4", bus.rs2_data, 32'h0);
        cyc(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 3'd4);
        chk("post_rst_o1", bus.rs1_data, 32'h0);

        // 2: globals and %g0
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 3'd0);
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h5, 3'd0);
        cyc(1'b1, 5'd0, 5'd5, 1'b0, 5'd0, 32'h0, 3'd0);
        chk("g0_reads_zero", bus.rs1_data, 32'h0);
        chk("g5_read", bus.rs2_data, 32'h5);
        chk("g_valid", {31'b0, bus.rd_valid}, 32'h1);
        idle();
        chk("valid_one_cycle", {31'b0, bus.rd_valid}, 32'h0);
        chk("idle_hold_rs2", bus.rs2_data, 32'h5);

        // 3: outs of window 3 are ins of window 2; locals private
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 32'hA5A5_0001, 3'd3);
        cyc(1'b1, 5'd24, 5'd16, 1'b0, 5'd0, 32'h0, 3'd2);
        chk("ovl_in_w2", bus.rs1_data, 32'hA5A5_0001);
        chk("ovl_local_w2", bus.rs2_data, 32'h0);
        cyc(1'b1, 5'd16, 5'd8, 1'b0, 5'd0, 32'h0, 3'd3);
        chk("ovl_local_w3", bus.rs1_data, 32'h0);
        chk("ovl_out_w3", bus.rs2_data, 32'hA5A5_0001);

        // 4: window 7 ins wrap onto window 0 outs
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd10, 32'h77, 3'd0);
        cyc(1'b1, 5'd26, 5'd10, 1'b0, 5'd0, 32'h0, 3'd7);
        chk("wrap_in_w7", bus.rs1_data, 32'h77);
        chk("wrap_out_w7", bus.rs2_data, 32'h0);

        // 5: same-cycle write and read of r17 in window 1
`ifdef RF_WR_BYPASS_EN
        coll_exp = 32'h1234;
`else
        coll_exp = 32'h0;
`endif
        cyc(1'b1, 5'd17, 5'd17, 1'b1, 5'd17, 32'h1234, 3'd1);
        chk("coll_rs1", bus.rs1_data, coll_exp);
        chk("coll_rs2", bus.rs2_data, coll_exp);
        cyc(1'b1, 5'd17, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 3'd1);
        chk("coll_after", bus.rs1_data, 32'h1234);
        chk("coll_g0", bus.rs2_data, 32'h0);

        // 6: outputs hold while rd_en is low, even as the source is rewritten
        cyc(1'b1, 5'd17, 5'd5, 1'b0, 5'd0, 32'h0, 3'd1);
        chk("hold_pulse_rs1", bus.rs1_data, 32'h1234);
        chk("hold_pulse_rs2", bus.rs2_data, 32'h5);
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 5'd17, 5'd5, 1'b1, 5'd17, 32'(k), 3'd1);
            chk("hold_rs1", bus.rs1_data, 32'h1234);
            chk("hold_valid", {31'b0, bus.rd_valid}, 32'h0);
        end
        cyc(1'b1, 5'd17, 5'd17, 1'b0, 5'd0, 32'h0, 3'd1);
        chk("hold_reread", bus.rs1_data, 32'h3);
        chk("hold_reread_valid", {31'b0, bus.rd_valid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
